// File: rtl/ndp_job_scheduler.sv
// ndp_job_scheduler: round-robin arbiter sharing one NDP core between NUM_REQ job requesters.
// Optional WAIT_DONE watchdog enabled by defining NDP_SCHED_TIMEOUT_EN.
module ndp_job_scheduler #(
  parameter int NUM_REQ        = 4,
  parameter int ID_W           = 2,
  parameter int CLR_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [32*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]    req_last,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic [NUM_REQ-1:0]    res_valid,
  input  logic [NUM_REQ-1:0]    res_ack,
  output logic [NUM_REQ-1:0]    res_error,
  output logic                  core_data_in_flag,
  output logic [31:0]           core_data_in,
  input  logic                  core_data_read_flag,
  input  logic                  core_calc_done_flag,
  output logic                  core_reset,
  output logic [ID_W-1:0]       grant_id,
  output logic                  busy,
  output logic                  proto_err
);
  localparam int CW = $clog2(CLR_CYCLES + 1);
  typedef enum logic [2:0] {IDLE, STREAM, WAIT_DONE, HOLD, CLEAR} state_t;
  state_t state_q, state_d;
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d, grant_q, grant_d, pick, idx;
  logic [NUM_REQ-1:0] res_valid_q, res_valid_d;
  logic [CW-1:0] clr_q, clr_d;
  logic proto_err_q, proto_err_d, xfer_q, xfer_d, core_reset_q, busy_q;
  logic vg, rdy, timeout;
  if (NUM_REQ < 2 || (1 << ID_W) < NUM_REQ || CLR_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("ndp_job_scheduler: invalid parameters");
  end
  assign vg                = req_valid[grant_q];
  assign rdy               = state_q == STREAM && vg && core_data_read_flag;
  assign req_ready         = rdy ? NUM_REQ'(1) << grant_q : '0;
  assign core_data_in_flag = state_q == STREAM && vg;
  assign core_data_in      = req_data[32*grant_q +: 32];
  assign res_valid         = res_valid_q;
  assign core_reset        = core_reset_q;
  assign grant_id          = grant_q;
  assign busy              = busy_q;
  assign proto_err         = proto_err_q;
`ifdef NDP_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_q;
  logic [NUM_REQ-1:0] res_error_q;
  assign timeout   = state_q == WAIT_DONE && !core_calc_done_flag && to_q == TW'(TIMEOUT_CYCLES - 1);
  assign res_error = res_error_q;
  always_ff @(posedge clk) begin
    to_q        <= (reset || state_q != WAIT_DONE) ? '0 : to_q + 1'b1;
    res_error_q <= (!reset && timeout) ? NUM_REQ'(1) << grant_q : '0;
  end
`else
  assign timeout   = 1'b0;
  assign res_error = '0;
`endif
  // Descending scan so the requester closest to rr_ptr is the last (winning) assignment.
  always_comb begin
    pick = rr_ptr_q;
    idx  = rr_ptr_q;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = ID_W'((int'(rr_ptr_q) + k) % NUM_REQ);
      if (req_valid[idx]) pick = idx;
    end
  end
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_d     = grant_q;
    res_valid_d = res_valid_q;
    proto_err_d = proto_err_q;
    xfer_d      = xfer_q;
    clr_d       = state_q == CLEAR ? clr_q + 1'b1 : '0;
    unique case (state_q)
      IDLE: if (|req_valid) begin
        grant_d = pick;
        xfer_d  = 1'b0;
        state_d = STREAM;
      end
      STREAM: if (rdy) begin
        xfer_d  = 1'b1;
        state_d = req_last[grant_q] ? WAIT_DONE : STREAM;
      end else if (!vg && xfer_q) begin
        proto_err_d = 1'b1;
        state_d     = WAIT_DONE;
      end
      WAIT_DONE: if (core_calc_done_flag) begin
        res_valid_d[grant_q] = 1'b1;
        state_d              = HOLD;
      end else if (timeout) state_d = CLEAR;
      HOLD: if (res_ack[grant_q]) begin
        res_valid_d[grant_q] = 1'b0;
        state_d              = CLEAR;
      end
      CLEAR: if (clr_q == CW'(CLR_CYCLES - 1)) begin
        state_d  = IDLE;
        rr_ptr_d = grant_q == ID_W'(NUM_REQ - 1) ? '0 : grant_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      grant_q      <= '0;
      res_valid_q  <= '0;
      proto_err_q  <= 1'b0;
      xfer_q       <= 1'b0;
      clr_q        <= '0;
      core_reset_q <= 1'b1;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      grant_q      <= grant_d;
      res_valid_q  <= res_valid_d;
      proto_err_q  <= proto_err_d;
      xfer_q       <= xfer_d;
      clr_q        <= clr_d;
      core_reset_q <= state_d == CLEAR;
      busy_q       <= state_d != IDLE;
    end
  end
endmodule

// File: doc/ndp_job_scheduler.md
Name: ndp_job_scheduler

Overview:
Round-robin job scheduler that shares one NDP core between NUM_REQ requesters (expert/memory channels). A requester wins a grant and streams its 32-bit job words into the core. The scheduler then waits for the core's calculation-done flag and holds the result until the requester acknowledges it. It finally pulses a core clear so the accumulators are empty for the next job. It sits between the channel front-ends and the NDP core's data_in/data_read/calc_done interface.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
ID_W, 2, width of grant_id; must satisfy 2**ID_W >= NUM_REQ
CLR_CYCLES, 2, cycles core_reset is held after each job (>=1)
TIMEOUT_CYCLES, 4096, watchdog limit in WAIT_DONE (used only with the optional feature)

Ports:
clk  in  1  clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
req_valid  in  NUM_REQ  per-requester word valid
req_data  in  32*NUM_REQ  per-requester word; slice i = [32*i+31:32*i]
req_last  in  NUM_REQ  marks final word of the job
req_ready  out  NUM_REQ  word accepted this cycle (one-hot or zero)
res_valid  out  NUM_REQ  result held in core for requester i
res_ack  in  NUM_REQ  requester has consumed the result
res_error  out  NUM_REQ  one-cycle pulse on job abort (optional feature only)
core_data_in_flag  out  1  to core data_in_flag
core_data_in  out  32  to core data_in
core_data_read_flag  in  1  from core data_read_flag
core_calc_done_flag  in  1  from core calc_done_flag
core_reset  out  1  core reset/clear
grant_id  out  ID_W  index of the current grantee
busy  out  1  state != IDLE
proto_err  out  1  sticky: valid gap before last

Behaviour:
- States: IDLE, STREAM, WAIT_DONE, HOLD, CLEAR. All state and outputs are registered except req_ready, core_data_in_flag and core_data_in, which are combinational from state/grant.
- Reset values: state=IDLE, rr_ptr=0, grant_id=0, res_valid=0, res_error=0, proto_err=0, core_reset=1, busy=0. core_reset = reset OR (state==CLEAR).
- IDLE: if any req_valid, grant the first requester set at or after rr_ptr (cyclic search). Register grant_id, go to STREAM next cycle. No words are accepted in IDLE.
- STREAM: core_data_in_flag = req_valid[g]; core_data_in = req_data slice g; req_ready[g] = req_valid[g] & core_data_read_flag.
- Transfer: a word moves on req_valid[g] & req_ready[g]. A transfer with req_last[g] moves the state to WAIT_DONE.
- Gap handling: if req_valid[g] is low in STREAM after at least one transfer, set proto_err, treat the job as ended, and go to WAIT_DONE.
- WAIT_DONE: core_data_in_flag=0. When core_calc_done_flag=1, set res_valid[g] and go to HOLD.
- HOLD: res_valid[g] stays high until res_ack[g]=1, then clear res_valid and go to CLEAR. res_ack of non-granted requesters is ignored. The ack may arrive in the same cycle res_valid is first seen high.
- CLEAR: core_reset=1 for exactly CLR_CYCLES cycles. Then rr_ptr = (g+1) mod NUM_REQ and state=IDLE.
- Fairness: a requester re-requesting immediately yields to any other pending requester.
- Simultaneous requests: the lowest index at or after rr_ptr wins. Other requesters see req_ready=0 for the whole job.
- Reset mid-operation: immediate return to reset values. The partially streamed job is dropped and core_reset is asserted.
- Latency: IDLE to first possible transfer is 1 cycle. Job end (after ack) to next grant is CLR_CYCLES+1 cycles.

Optional Feature:
NDP_SCHED_TIMEOUT_EN.
- Defined: a counter clears on entry to WAIT_DONE and increments each cycle. If it reaches TIMEOUT_CYCLES without core_calc_done_flag, pulse res_error[g] for 1 cycle, skip HOLD and go to CLEAR.
- Not defined: no counter; res_error is tied to 0; WAIT_DONE waits indefinitely.

Test Plan:
- Single job: req0 streams 6 words (0x1..0x6, last on 6), core read_flag=1, calc_done 10 cycles later -> 6 transfers, res_valid[0]=1 until ack, then core_reset high for 2 cycles, grant returns to IDLE.
- Contention: req_valid=4'b1011 held with rr_ptr=0 -> grant order 0,1,3,0; grant_id matches each job; req_ready never has two bits set.
- Backpressure: core_data_read_flag toggles 1,0,1,0 during a 4-word job -> exactly 4 transfers, no word duplicated or skipped, core_data_in stable while read_flag=0.
- Gap: req2 drops valid after 3 words, no last -> proto_err=1 (sticky), WAIT_DONE entered, and the job completes normally after calc_done and ack.
- Reset mid-STREAM after 2 words -> next cycle state=IDLE, core_reset=1, res_valid=0, rr_ptr=0.
- With NDP_SCHED_TIMEOUT_EN and TIMEOUT_CYCLES=16, calc_done never asserted -> res_error[g] pulses at cycle 16 of WAIT_DONE, then CLEAR, then IDLE. Without the macro -> busy stays 1.
